useq_sequencer: RTL and testbench
=================================

Name: useq_sequencer

Overview:
- Microprogram sequencer for the two-register compute datapath.
- Holds a writable microcode store, steps a program counter through it, and emits per-cycle datapath control words {op, sw, wb, wa}.
- Branches on the comparator result cres.
- Adds a start/busy/done handshake so a host can load a program and run it on demand.

Parameters:
- P_LOG_MEMSIZE, 4: log2 of microcode depth; pc width.
- P_NUM_D_CTRLBITS, 5: datapath control field width (pd_ctrl).
- P_NUM_C_CTRLBITS, 2: sequencing field width; fixed encoding below, must be 2.
- P_WD_LIMIT, 255: watchdog limit in RUN cycles; used only with USEQ_WATCHDOG_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_we  in  1  microcode write strobe.
- prog_addr  in  P_LOG_MEMSIZE  write address.
- prog_data  in  W  microword, W = P_NUM_D_CTRLBITS+P_NUM_C_CTRLBITS+P_LOG_MEMSIZE.
- start  in  1  run request, sampled in IDLE only.
- cres  in  1  comparator result from the datapath.
- pd_ctrl  out  P_NUM_D_CTRLBITS  datapath control {op, sw, wb, wa}.
- pc  out  P_LOG_MEMSIZE  current program counter.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  watchdog abort flag; tied 0 without the macro.

Behaviour:
- Microword layout, MSB to LSB: [dctrl | cctrl | target].
- cctrl encoding:
  - 00 NEXT: pc+1.
  - 01 JUMP: pc=target.
  - 10 BRZ: pc=target if cres=1, else pc+1.
  - 11 HALT.
- Microcode store: 2^P_LOG_MEMSIZE x W, synchronous write, combinational read at pc. Not cleared by rst; contents survive reset.
- Reset state: state=IDLE, pc=0, pd_ctrl=0, busy=0, done=0, err=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - pd_ctrl=0.
  - prog_we writes mem[prog_addr].
  - start=1 -> RUN with pc=0 at the next edge.
  - start and prog_we in the same cycle: both take effect; the write is visible to the run.
  - err clears on accepted start.
- RUN:
  - busy=1.
  - pd_ctrl = dctrl of mem[pc], combinational in the same cycle.
  - pc updates each edge per cctrl; cres is sampled in the same cycle as the BRZ word.
- HALT word:
  - Its dctrl is still driven for that one cycle, so a final register write is allowed.
  - Next edge -> DONE.
- DONE:
  - done=1, busy=0, pd_ctrl=0 for exactly one cycle, then IDLE.
  - start in DONE is ignored.
- pc arithmetic is modulo 2^P_LOG_MEMSIZE; NEXT at the max address wraps to 0.
- prog_we in RUN or DONE is dropped; memory is unchanged.
- start while not IDLE is ignored.
- rst mid-run: immediate return to reset state. pd_ctrl drops to 0 asynchronously; no done pulse.
- Latency: first control word appears in the cycle after start is sampled. An N-word straight-line program ending in HALT gives busy for N cycles, then done.

Optional Feature:
- Macro: USEQ_WATCHDOG_EN.
- With the macro:
  - A counter counts RUN cycles from start.
  - If RUN lasts P_WD_LIMIT cycles without reaching HALT, the next edge forces IDLE: pc=0, pd_ctrl=0, busy=0, err=1, no done pulse.
  - err stays set until the next accepted start or rst.
  - The counter resets on entry to RUN.
- Without the macro: no counter, err constant 0, and RUN may last indefinitely.

Test Plan:
- Straight-line run. Load mem0={dctrl=01,NEXT}, mem1={02,NEXT}, mem2={03,HALT}, then pulse start. Required: pd_ctrl=01,02,03 on three consecutive cycles with busy=1; done=1 on the 4th cycle; IDLE on the 5th.
- Branch on cres. mem0={00,BRZ,target=5}. With cres=1: pc goes 0 then 5. Rerun with cres=0: pc goes 0 then 1.
- Wrap-around. mem15={04,NEXT}, mem0={00,HALT}, start via mem0={00,JUMP,15}. Required pc sequence: 0, 15, 0; HALT is reached on the second visit only after mem0 is reprogrammed, so also confirm pc returns to 0 after 15.
- Reset mid-run. Assert rst when pc=3. Required: pd_ctrl=0, busy=0, pc=0 before the next edge. A rerun without reloading gives an identical pd_ctrl trace.
- Protected store. Write mem1=07 during RUN. Required: the run and a subsequent run still output the original mem1 dctrl; start pulses during RUN and DONE are ignored.
- Watchdog, with macro and P_WD_LIMIT=8. Program mem0={01,JUMP,0}. Required: busy for 8 cycles, then err=1, busy=0, done never asserted. Without the macro: busy remains 1 after 100 cycles and err=0.

Source files
------------

// File: rtl/useq_sequencer.sv
// Microprogram sequencer: writable microcode store, pc stepping, start/busy/done handshake.
// Define USEQ_WATCHDOG_EN to abort runs that exceed P_WD_LIMIT cycles (sets err).
module useq_sequencer #(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_NUM_C_CTRLBITS = 2,
  parameter int P_WD_LIMIT       = 255
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       prog_we,
  input  logic [P_LOG_MEMSIZE-1:0]                                   prog_addr,
  input  logic [P_NUM_D_CTRLBITS+P_NUM_C_CTRLBITS+P_LOG_MEMSIZE-1:0] prog_data,
  input  logic                                                       start,
  input  logic                                                       cres,
  output logic [P_NUM_D_CTRLBITS-1:0]                                pd_ctrl,
  output logic [P_LOG_MEMSIZE-1:0]                                   pc,
  output logic                                                       busy,
  output logic                                                       done,
  output logic                                                       err
);

  localparam int W         = P_NUM_D_CTRLBITS + P_NUM_C_CTRLBITS + P_LOG_MEMSIZE;
  localparam int MEM_DEPTH = 1 << P_LOG_MEMSIZE;

  localparam logic [P_NUM_C_CTRLBITS-1:0] CC_NEXT = P_NUM_C_CTRLBITS'(0);
  localparam logic [P_NUM_C_CTRLBITS-1:0] CC_JUMP = P_NUM_C_CTRLBITS'(1);
  localparam logic [P_NUM_C_CTRLBITS-1:0] CC_BRZ  = P_NUM_C_CTRLBITS'(2);
  localparam logic [P_NUM_C_CTRLBITS-1:0] CC_HALT = P_NUM_C_CTRLBITS'(3);

  if (P_NUM_C_CTRLBITS != 2 || P_WD_LIMIT < 1) begin : g_cfg_check
    $error("useq_sequencer: sequencing field must be 2 bits and watchdog limit >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                      state_r;
  logic [W-1:0]                mem_r [MEM_DEPTH];
  logic [W-1:0]                word_s;
  logic [P_NUM_D_CTRLBITS-1:0] dctrl_s;
  logic [P_NUM_C_CTRLBITS-1:0] cctrl_s;
  logic [P_LOG_MEMSIZE-1:0]    target_s;
  logic [P_LOG_MEMSIZE-1:0]    pc_inc_s;
  logic [P_LOG_MEMSIZE-1:0]    pc_next_s;
  logic                        wd_trip_s;

`ifdef USEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(P_WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt_r;
  // The counter holds (RUN cycles so far - 1), so it trips during the last allowed cycle.
  assign wd_trip_s = (wd_cnt_r == WD_W'(P_WD_LIMIT - 1));
`else
  assign wd_trip_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Decode the current microword and compute the following pc.
  always_comb begin
    word_s    = mem_r[pc];
    dctrl_s   = word_s[W-1 -: P_NUM_D_CTRLBITS];
    cctrl_s   = word_s[P_LOG_MEMSIZE +: P_NUM_C_CTRLBITS];
    target_s  = word_s[P_LOG_MEMSIZE-1:0];
    pc_inc_s  = pc + P_LOG_MEMSIZE'(1);
    case (cctrl_s)
      CC_NEXT: pc_next_s = pc_inc_s;
      CC_JUMP: pc_next_s = target_s;
      CC_BRZ:  pc_next_s = cres ? target_s : pc_inc_s;
      default: pc_next_s = pc;
    endcase
  end

  // Control word follows the store combinationally in RUN; an async reset forces IDLE and hence zero.
  assign pd_ctrl = (state_r == ST_RUN) ? dctrl_s : {P_NUM_D_CTRLBITS{1'b0}};

  // Microcode store: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_r == ST_IDLE)) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pc       <= {P_LOG_MEMSIZE{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef USEQ_WATCHDOG_EN
      wd_cnt_r <= {WD_W{1'b0}};
      err      <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= ST_RUN;
            pc       <= {P_LOG_MEMSIZE{1'b0}};
            busy     <= 1'b1;
`ifdef USEQ_WATCHDOG_EN
            wd_cnt_r <= {WD_W{1'b0}};
            err      <= 1'b0;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cctrl_s == CC_HALT) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (wd_trip_s) begin
            state_r <= ST_IDLE;
            pc      <= {P_LOG_MEMSIZE{1'b0}};
            busy    <= 1'b0;
`ifdef USEQ_WATCHDOG_EN
            err     <= 1'b1;
`endif
          end else begin
            pc       <= pc_next_s;
`ifdef USEQ_WATCHDOG_EN
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
`endif
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          pc      <= {P_LOG_MEMSIZE{1'b0}};
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          pc      <= {P_LOG_MEMSIZE{1'b0}};
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_useq_sequencer.sv
// Randomised bench for useq_sequencer: per-run traces come from a program-level model of the store.
module tb_useq_sequencer;
  localparam int WD    = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [10:0] prog_data = 11'd0;
  logic        start = 1'b0;
  logic        cres = 1'b0;
  logic [4:0]  pd_ctrl;
  logic [3:0]  pc;
  logic        busy, done, err;

  useq_sequencer #(.P_LOG_MEMSIZE(4), .P_NUM_D_CTRLBITS(5), .P_NUM_C_CTRLBITS(2),
                   .P_WD_LIMIT(WD)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .cres(cres), .pd_ctrl(pd_ctrl), .pc(pc), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [10:0] mdl_mem [DEPTH];
  bit          mdl_err = 1'b0;
  bit          chk_en = 1'b0;
  bit          chk_pc = 1'b0;
  int          exp_ctrl = 0;
  int          exp_pc = 0;
  bit          exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  int          last_n;
  bit          last_halt, last_wd;
  int          last_pc[$];
  int          last_ctrl[$];
  int          saved_ctrl[$];

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, want, $time);
    end
  endtask

  // Single compare point: outputs are checked against the current expectation every negedge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pd_ctrl", int'(pd_ctrl), exp_ctrl);
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      chk("err", int'(err), int'(exp_err));
      if (chk_pc) chk("pc", int'(pc), exp_pc);
    end
  end

  function automatic logic [10:0] mw(input int d, input int c, input int t);
    return {5'(d), 2'(c), 4'(t)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_ctrl = 0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = mdl_err; chk_pc = 1'b0;
  endtask

  task automatic load(input int a, input logic [10:0] d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d; mdl_mem[a] = d;
    tick();
    prog_we = 1'b0;
  endtask

  // cres_mode: 0 always 0, 1 always 1, 3 high on first word only, else random.
  task automatic run_prog(input int max_cyc, input int cres_mode, input bit noise, input bit wr_at_start);
    int p, cc, tg, a;
    bit c;
    bit tc[$];
    logic [10:0] w;
    if (wr_at_start) begin
      a = $urandom_range(0, DEPTH-1);
      w = 11'($urandom);
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = w; mdl_mem[a] = w;
    end
    start = 1'b1;
    p = 0; last_n = 0; last_halt = 1'b0; last_wd = 1'b0;
    last_pc.delete(); last_ctrl.delete();
    while (1) begin
      case (cres_mode)
        0: c = 1'b0;
        1: c = 1'b1;
        3: c = (last_n == 0);
        default: c = 1'($urandom);
      endcase
      w = mdl_mem[p];
      last_pc.push_back(p); last_ctrl.push_back(int'(w[10:6])); tc.push_back(c);
      last_n++;
      cc = int'(w[5:4]); tg = int'(w[3:0]);
      if (cc == 3) begin last_halt = 1'b1; break; end
`ifdef USEQ_WATCHDOG_EN
      if (last_n == WD) begin last_wd = 1'b1; break; end
`endif
      if (last_n == max_cyc) break;
      if (cc == 1 || (cc == 2 && c)) p = tg;
      else p = (p + 1) % DEPTH;
    end

    tick();
    start = 1'b0; prog_we = 1'b0; mdl_err = 1'b0;
    for (int k = 0; k < last_n; k++) begin
      exp_pc = last_pc[k]; exp_ctrl = last_ctrl[k];
      exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0; chk_pc = 1'b1;
      cres = tc[k];
      if (noise) begin
        start = 1'($urandom); prog_we = 1'b1; prog_addr = 4'd1; prog_data = mw(7, 0, 0);
      end
      if (!(k == last_n - 1 && !last_halt && !last_wd)) tick();
    end

    if (last_halt) begin
      exp_ctrl = 0; exp_busy = 1'b0; exp_done = 1'b1; exp_err = 1'b0; chk_pc = 1'b0;
      tick();
      start = 1'b0; prog_we = 1'b0;
      idle_exp();
    end else if (last_wd) begin
      start = 1'b0; prog_we = 1'b0;
      mdl_err = 1'b1;
      idle_exp();
    end else begin
      @(negedge clk);
      #1;
      start = 1'b0; prog_we = 1'b0;
      mdl_err = 1'b0;
      idle_exp(); chk_pc = 1'b1; exp_pc = 0;
      rst = 1'b1;
      #1;
      chk("rst_pd_ctrl", int'(pd_ctrl), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      tick();
      rst = 1'b0;
      tick();
      idle_exp();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", int'(pc), 0);
    chk("reset_pd_ctrl", int'(pd_ctrl), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    idle_exp();
    chk_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) load(a, mw(0, 3, 0));

    // straight-line program
    load(0, mw(1, 0, 0)); load(1, mw(2, 0, 0)); load(2, mw(3, 3, 0));
    run_prog(50, 2, 1'b0, 1'b0);
    chk("sl_len", last_n, 3);
    chk("sl_halt", int'(last_halt), 1);
    chk("sl_ctrl0", last_ctrl[0], 1);
    chk("sl_ctrl1", last_ctrl[1], 2);
    chk("sl_ctrl2", last_ctrl[2], 3);
    tick();

    // branch taken / not taken
    load(0, mw(0, 2, 5)); load(5, mw(9, 3, 0)); load(1, mw(10, 3, 0));
    run_prog(50, 1, 1'b0, 1'b0);
    chk("brz_taken_pc", last_pc[1], 5);
    run_prog(50, 0, 1'b0, 1'b0);
    chk("brz_fall_pc", last_pc[1], 1);

    // wrap-around
    load(0, mw(0, 1, 15)); load(15, mw(4, 0, 0));
    run_prog(3, 2, 1'b0, 1'b0);
    chk("wrap_pc1", last_pc[1], 15);
    chk("wrap_pc2", last_pc[2], 0);
    load(0, mw(0, 2, 15));
    run_prog(50, 3, 1'b0, 1'b0);
    chk("wrap2_len", last_n, 4);
    chk("wrap2_pc3", last_pc[3], 1);
    chk("wrap2_ctrl1", last_ctrl[1], 4);

    // reset mid-run at pc=3, then identical rerun
    for (int a = 0; a < 4; a++) load(a, mw(17 + a, 0, 0));
    load(4, mw(21, 3, 0));
    run_prog(4, 2, 1'b0, 1'b0);
    chk("rst_run_pc3", last_pc[3], 3);
    saved_ctrl = last_ctrl;
    run_prog(50, 2, 1'b0, 1'b0);
    chk("rerun_len", last_n, 5);
    for (int k = 0; k < 4; k++) chk("rerun_trace", last_ctrl[k], saved_ctrl[k]);

    // protected store: writes and starts during RUN/DONE are dropped
    load(0, mw(1, 0, 0)); load(1, mw(2, 0, 0)); load(2, mw(3, 3, 0));
    run_prog(50, 2, 1'b1, 1'b0);
    run_prog(50, 2, 1'b0, 1'b0);
    chk("prot_ctrl1", last_ctrl[1], 2);

    // watchdog / unbounded run
    load(0, mw(1, 1, 0));
    run_prog(100, 2, 1'b0, 1'b0);
`ifdef USEQ_WATCHDOG_EN
    chk("wd_len", last_n, WD);
    chk("wd_flag", int'(last_wd), 1);
    chk("wd_err_out", int'(err), 1);
`else
    chk("nowd_len", last_n, 100);
    chk("nowd_flag", int'(last_wd), 0);
`endif
    tick();

    // randomised programs
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++) load(a, 11'($urandom));
      run_prog(40, 2, ($urandom_range(0, 3) == 0), 1'($urandom));
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
